// File: rtl/thread_suspend_controller.sv
// Per-thread suspend/wake tracking for the thread select stage: block state and reason,
// suspend/wake race handling, protocol violation flagging and stuck-thread timeout detection.

module thread_suspend_lane #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_suspend,
  input  logic i_suspend_is_io,
  input  logic i_dwake,
  input  logic i_iwake,
  output logic o_blocked,
  output logic o_blocked_nxt,
  output logic o_is_io,
  output logic o_timeout,
  output logic o_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RUNNING = 1'b0, SUSPENDED = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_is_io, w_is_io_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_sticky, w_sticky_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic            w_err;
  logic            w_wake_match, w_wake_mismatch, w_race_match;

  assign w_wake_match    = r_is_io ? i_iwake : i_dwake;
  assign w_wake_mismatch = r_is_io ? i_dwake : i_iwake;
  assign w_race_match    = i_suspend_is_io ? i_iwake : i_dwake;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUNNING;
      r_is_io   <= 1'b0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_is_io   <= w_is_io_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sticky  <= w_sticky_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_is_io_nxt   = r_is_io;
    w_cnt_nxt     = r_cnt;
    w_sticky_nxt  = r_sticky;
    w_timeout_nxt = 1'b0;
    w_err         = i_dwake & i_iwake;
    case (r_state)
      RUNNING: begin
        if (i_suspend) begin
          // A matching wake in the same cycle means the fill already landed.
          if (!w_race_match) begin
            w_state_nxt  = SUSPENDED;
            w_is_io_nxt  = i_suspend_is_io;
            w_cnt_nxt    = '0;
            w_sticky_nxt = 1'b0;
            if (i_dwake | i_iwake) w_err = 1'b1;
          end
        end else if (i_dwake | i_iwake) begin
          w_err = 1'b1;
        end
      end
      SUSPENDED: begin
        if (i_suspend) w_err = 1'b1;
        if (w_wake_match) begin
          w_state_nxt  = RUNNING;
          w_sticky_nxt = 1'b0;
        end else begin
          if (w_wake_mismatch) w_err = 1'b1;
          if (r_cnt == CMAX && !r_sticky) begin
            w_timeout_nxt = 1'b1;
            w_sticky_nxt  = 1'b1;
          end
          if (r_cnt != CMAX) w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RUNNING;
    endcase
  end

  assign o_blocked     = (r_state == SUSPENDED);
  assign o_blocked_nxt = (w_state_nxt == SUSPENDED);
  assign o_is_io       = r_is_io & (r_state == SUSPENDED);
  assign o_timeout     = r_timeout;
  assign o_err         = w_err;
endmodule

module thread_suspend_controller #(
  parameter int NUM_THREADS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_THREADS-1:0]             i_suspend_oh,
  input  logic                               i_suspend_is_io,
  input  logic [NUM_THREADS-1:0]             i_dcache_wake_bitmap,
  input  logic [NUM_THREADS-1:0]             i_io_wake_bitmap,
  output logic [NUM_THREADS-1:0]             o_thread_blocked,
  output logic [NUM_THREADS-1:0]             o_blocked_is_io,
  output logic [$clog2(NUM_THREADS+1)-1:0]   o_blocked_count,
  output logic [NUM_THREADS-1:0]             o_timeout_oh,
  output logic                               o_protocol_error
);
  localparam int CNTW = $clog2(NUM_THREADS + 1);

  logic                   w_sus_ok;
  logic [NUM_THREADS-1:0] w_susp, w_blk_nxt, w_err;
  logic [CNTW-1:0]        w_count, r_count;
  logic                   r_perr;

  // A malformed suspend vector is dropped entirely so no thread changes state.
  assign w_sus_ok = ((i_suspend_oh & (i_suspend_oh - 1'b1)) == '0);
  assign w_susp   = w_sus_ok ? i_suspend_oh : '0;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    thread_suspend_lane #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_lane (
      .clk            (clk),
      .reset          (reset),
      .i_suspend      (w_susp[t]),
      .i_suspend_is_io(i_suspend_is_io),
      .i_dwake        (i_dcache_wake_bitmap[t]),
      .i_iwake        (i_io_wake_bitmap[t]),
      .o_blocked      (o_thread_blocked[t]),
      .o_blocked_nxt  (w_blk_nxt[t]),
      .o_is_io        (o_blocked_is_io[t]),
      .o_timeout      (o_timeout_oh[t]),
      .o_err          (w_err[t])
    );
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_THREADS; i++) w_count = w_count + CNTW'(w_blk_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_count <= w_count;
      r_perr  <= !w_sus_ok || (|w_err);
    end
  end

  assign o_blocked_count  = r_count;
  assign o_protocol_error = r_perr;
endmodule

// File: tb/tb_thread_suspend_controller.sv
// Directed bench for thread_suspend_controller with a short timeout (8 cycles).

module tb_thread_suspend_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sus = '0;
  logic       sus_io = 1'b0;
  logic [3:0] dw = '0;
  logic [3:0] iw = '0;
  logic [3:0] blk, bio, tmo;
  logic [2:0] cnt;
  logic       perr;
  int total = 0;
  int bad = 0;

  thread_suspend_controller #(.NUM_THREADS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_suspend_oh(sus), .i_suspend_is_io(sus_io),
    .i_dcache_wake_bitmap(dw), .i_io_wake_bitmap(iw),
    .o_thread_blocked(blk), .o_blocked_is_io(bio), .o_blocked_count(cnt),
    .o_timeout_oh(tmo), .o_protocol_error(perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    sus = '0; sus_io = 1'b0; dw = '0; iw = '0;
  endtask

  task automatic test_reset();
    #2;
    total++; if ({blk, bio, cnt, tmo, perr} !== 16'h0) begin bad++;
      $display("FAIL reset_state: got %h want 0", {blk, bio, cnt, tmo, perr}); end
    tick(); reset = 1'b0; tick();
    total++; if ({blk, bio, cnt, tmo, perr} !== 16'h0) begin bad++;
      $display("FAIL after_release: got %h want 0", {blk, bio, cnt, tmo, perr}); end
  endtask

  task automatic test_basic();
    sus = 4'b0010; sus_io = 1'b0; tick(); idle();
    total++; if (blk !== 4'b0010 || cnt !== 3'd1 || bio !== 4'b0000 || perr !== 1'b0) begin bad++;
      $display("FAIL basic_suspend: got blk=%b cnt=%0d bio=%b err=%b want 0010/1/0000/0", blk, cnt, bio, perr); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (blk !== 4'b0010 || cnt !== 3'd1 || perr !== 1'b0) begin bad++;
        $display("FAIL basic_hold%0d: got blk=%b cnt=%0d err=%b want 0010/1/0", k, blk, cnt, perr); end
    end
    dw = 4'b0010; tick(); idle();
    total++; if (blk !== 4'b0000 || cnt !== 3'd0 || perr !== 1'b0) begin bad++;
      $display("FAIL basic_wake: got blk=%b cnt=%0d err=%b want 0000/0/0", blk, cnt, perr); end
    tick();
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL basic_noerr: got %b want 0", perr); end
  endtask

  task automatic test_race();
    sus = 4'b0001; dw = 4'b0001; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b0) begin bad++;
      $display("FAIL race: got blk=%b err=%b want 0000/0", blk, perr); end
    tick();
    total++; if (perr !== 1'b0 || blk !== 4'b0000) begin bad++;
      $display("FAIL race_after: got blk=%b err=%b want 0000/0", blk, perr); end
  endtask

  task automatic test_wrong_source();
    sus = 4'b0100; sus_io = 1'b1; tick(); idle();
    total++; if (blk !== 4'b0100 || bio !== 4'b0100) begin bad++;
      $display("FAIL io_suspend: got blk=%b bio=%b want 0100/0100", blk, bio); end
    dw = 4'b0100; tick(); idle();
    total++; if (blk !== 4'b0100 || perr !== 1'b1) begin bad++;
      $display("FAIL wrong_src: got blk=%b err=%b want 0100/1", blk, perr); end
    tick();
    total++; if (blk !== 4'b0100 || perr !== 1'b0) begin bad++;
      $display("FAIL wrong_src_once: got blk=%b err=%b want 0100/0", blk, perr); end
    iw = 4'b0100; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b0) begin bad++;
      $display("FAIL io_wake: got blk=%b err=%b want 0000/0", blk, perr); end
  endtask

  task automatic test_timeout();
    sus = 4'b1000; tick(); idle();
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++; if (tmo !== ((k == 8) ? 4'b1000 : 4'b0000) || blk !== 4'b1000) begin bad++;
        $display("FAIL timeout_T+%0d: got tmo=%b blk=%b want %b/1000", k, tmo, blk, (k == 8) ? 4'b1000 : 4'b0000); end
    end
    dw = 4'b1000; tick(); idle();
    total++; if (blk !== 4'b0000 || tmo !== 4'b0000) begin bad++;
      $display("FAIL timeout_wake: got blk=%b tmo=%b want 0000/0000", blk, tmo); end
    // Wake on the last counted cycle suppresses the pulse.
    sus = 4'b1000; tick(); idle();
    for (int k = 1; k <= 7; k++) tick();
    dw = 4'b1000; tick(); idle();
    total++; if (blk !== 4'b0000 || tmo !== 4'b0000) begin bad++;
      $display("FAIL timeout_edge_wake: got blk=%b tmo=%b want 0000/0000", blk, tmo); end
    sus = 4'b1000; tick(); idle();
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++; if (tmo !== ((k == 8) ? 4'b1000 : 4'b0000)) begin bad++;
        $display("FAIL timeout_again_T+%0d: got %b want %b", k, tmo, (k == 8) ? 4'b1000 : 4'b0000); end
    end
    dw = 4'b1000; tick(); idle();
    total++; if (blk !== 4'b0000) begin bad++; $display("FAIL timeout_cleanup: got %b want 0000", blk); end
  endtask

  task automatic test_violations();
    sus = 4'b0011; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b1) begin bad++;
      $display("FAIL multi_hot: got blk=%b err=%b want 0000/1", blk, perr); end
    tick();
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL multi_hot_once: got %b want 0", perr); end
    sus = 4'b0010; tick(); idle();
    total++; if (blk !== 4'b0010 || perr !== 1'b0) begin bad++;
      $display("FAIL legal_suspend: got blk=%b err=%b want 0010/0", blk, perr); end
    sus = 4'b0010; sus_io = 1'b1; tick(); idle();
    total++; if (blk !== 4'b0010 || bio !== 4'b0000 || perr !== 1'b1) begin bad++;
      $display("FAIL double_suspend: got blk=%b bio=%b err=%b want 0010/0000/1", blk, bio, perr); end
    tick();
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL double_suspend_once: got %b want 0", perr); end
    iw = 4'b0001; tick(); idle();
    total++; if (blk !== 4'b0010 || perr !== 1'b1) begin bad++;
      $display("FAIL wake_running: got blk=%b err=%b want 0010/1", blk, perr); end
    tick();
    total++; if (perr !== 1'b0) begin bad++; $display("FAIL wake_running_once: got %b want 0", perr); end
    dw = 4'b0010; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b0) begin bad++;
      $display("FAIL viol_cleanup: got blk=%b err=%b want 0000/0", blk, perr); end
  endtask

  task automatic test_back_to_back();
    sus = 4'b0001; sus_io = 1'b1; tick(); idle();
    sus = 4'b0010; sus_io = 1'b0; iw = 4'b0001; tick(); idle();
    total++; if (blk !== 4'b0010 || cnt !== 3'd1 || perr !== 1'b0) begin bad++;
      $display("FAIL b2b: got blk=%b cnt=%0d err=%b want 0010/1/0", blk, cnt, perr); end
    dw = 4'b0010; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b0) begin bad++;
      $display("FAIL b2b_wake: got blk=%b err=%b want 0000/0", blk, perr); end
  endtask

  task automatic test_reset_mid();
    sus = 4'b0001; tick(); sus = 4'b0010; tick(); idle();
    total++; if (blk !== 4'b0011 || cnt !== 3'd2) begin bad++;
      $display("FAIL pre_reset: got blk=%b cnt=%0d want 0011/2", blk, cnt); end
    #2 reset = 1'b1; #1;
    total++; if ({blk, bio, cnt, tmo, perr} !== 16'h0) begin bad++;
      $display("FAIL async_reset: got %h want 0", {blk, bio, cnt, tmo, perr}); end
    tick(); reset = 1'b0;
    dw = 4'b0001; tick(); idle();
    total++; if (blk !== 4'b0000 || perr !== 1'b1) begin bad++;
      $display("FAIL post_reset_wake: got blk=%b err=%b want 0000/1", blk, perr); end
    tick();
    total++; if (perr !== 1'b0 || tmo !== 4'b0000) begin bad++;
      $display("FAIL post_reset_quiet: got err=%b tmo=%b want 0/0000", perr, tmo); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_race();
    test_wrong_source();
    test_timeout();
    test_violations();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
